// File: rtl/bgpu_pkg.sv
// bgpu_pkg
//   Shared types for the memory-fence controller.
//   Contents:
//     DefaultNumTags - default number of instruction tags per warp
//     fence_state_e  - fence controller state (IDLE, DRAIN, DONE), 2 bits
//   Configuration macro used by importers: BGPU_FENCE_BLOCK_ALL_EN
package bgpu_pkg;

  localparam int unsigned DefaultNumTags = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } fence_state_e;

endpackage : bgpu_pkg

// File: rtl/mem_tag_tracker.sv
// mem_tag_tracker
//   Tracks which tags belong to memory instructions still in flight and
//   keeps the snapshot a fence waits on.
//   Ports:
//     clk_i            in   clock
//     rst_ni           in   synchronous active-low reset
//     set_valid_i      in   forwarded memory handshake this cycle
//     set_tag_i        in   tag of that memory instruction
//     clr_valid_i      in   a memory instruction retires this cycle
//     clr_tag_i        in   tag of the retiring instruction
//     snap_take_i      in   fence handshake: load snapshot from the mask
//     snapshot_empty_o out  snapshot value for the next cycle is all zero
module mem_tag_tracker
  import bgpu_pkg::*;
#(
  parameter int unsigned NumTags  = DefaultNumTags,
  parameter int unsigned TagWidth = $clog2(NumTags)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                set_valid_i,
  input  logic [TagWidth-1:0] set_tag_i,
  input  logic                clr_valid_i,
  input  logic [TagWidth-1:0] clr_tag_i,
  input  logic                snap_take_i,
  output logic                snapshot_empty_o
);

  logic [NumTags-1:0] outstanding_reg;
  logic [NumTags-1:0] outstanding_next;
  logic [NumTags-1:0] snapshot_reg;
  logic [NumTags-1:0] snapshot_next;

  genvar gi;
  generate
    for (gi = 0; gi < NumTags; gi++) begin : g_tag
      logic set_hit;
      logic clr_hit;

      assign set_hit = set_valid_i && (set_tag_i == TagWidth'(gi));
      assign clr_hit = clr_valid_i && (clr_tag_i == TagWidth'(gi));

      // A new issue on a tag overrides a retire of the same tag in the
      // same cycle: the new instruction is the one still in flight.
      assign outstanding_next[gi] = set_hit ? 1'b1 :
                                    clr_hit ? 1'b0 : outstanding_reg[gi];

      // The snapshot never gains bits after it is taken; a same-cycle
      // retire is removed from it at capture time.
      assign snapshot_next[gi] = snap_take_i ? (outstanding_reg[gi] && !clr_hit) :
                                 clr_hit     ? 1'b0 : snapshot_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      outstanding_reg <= '0;
      snapshot_reg    <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      snapshot_reg    <= snapshot_next;
    end
  end

  // Looking at the next-cycle value lets the controller reach DONE one
  // cycle after the last waited-on tag retires.
  assign snapshot_empty_o = (snapshot_next == '0);

endmodule : mem_tag_tracker

// File: rtl/mem_fence_ctrl.sv
// mem_fence_ctrl
//   Memory-fence controller between dispatch and the operand collector.
//   Passes dispatch through combinationally, consumes fences, waits for
//   the memory tags outstanding at the fence to retire, then reports the
//   fence completion on the result path.
//   Ports:
//     clk_i, rst_ni                   clock, synchronous active-low reset
//     disp_valid_i / disp_ready_o     handshake with the wait buffer
//     disp_tag_i                      tag of the offered instruction
//     disp_is_mem_i / disp_is_fence_i instruction class
//     disp_valid_o / opc_ready_i      handshake with the operand collector
//     mem_retire_valid_i / _tag_i     memory instruction completion
//     fence_done_valid_o / _ready_i   fence completion to the result bus
//     fence_done_tag_o                tag of the completing fence
//     fence_active_o                  high while a fence is in progress
//   Configuration: define BGPU_FENCE_BLOCK_ALL_EN to block every dispatch
//   while a fence is in progress (full barrier); otherwise only memory
//   instructions and fences are held.
module mem_fence_ctrl
  import bgpu_pkg::*;
#(
  parameter int unsigned NumTags  = DefaultNumTags,
  parameter int unsigned TagWidth = $clog2(NumTags),
  parameter type         tag_t    = logic [TagWidth-1:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic disp_valid_i,
  output logic disp_ready_o,
  input  tag_t disp_tag_i,
  input  logic disp_is_mem_i,
  input  logic disp_is_fence_i,
  output logic disp_valid_o,
  input  logic opc_ready_i,
  input  logic mem_retire_valid_i,
  input  tag_t mem_retire_tag_i,
  output logic fence_done_valid_o,
  input  logic fence_done_ready_i,
  output tag_t fence_done_tag_o,
  output logic fence_active_o
);

  fence_state_e state_reg;
  fence_state_e state_next;
  tag_t         fence_tag_reg;
  tag_t         fence_tag_next;

  logic blocked;
  logic fence_fire;
  logic mem_set;
  logic snapshot_empty;

  always_comb begin
    state_next     = state_reg;
    fence_tag_next = fence_tag_reg;
    blocked        = 1'b0;
    fence_fire     = 1'b0;
    disp_valid_o   = 1'b0;
    disp_ready_o   = 1'b0;

    if (state_reg != IDLE) begin
`ifdef BGPU_FENCE_BLOCK_ALL_EN
      blocked = 1'b1;
`else
      blocked = disp_is_mem_i || disp_is_fence_i;
`endif
    end

    if (!rst_ni || blocked) begin
      disp_valid_o = 1'b0;
      disp_ready_o = 1'b0;
    end else if (disp_is_fence_i) begin
      // Fences stop here; the operand collector never sees them.
      disp_ready_o = 1'b1;
      fence_fire   = disp_valid_i;
    end else begin
      disp_valid_o = disp_valid_i;
      disp_ready_o = opc_ready_i;
    end

    unique case (state_reg)
      IDLE: begin
        if (fence_fire) begin
          fence_tag_next = disp_tag_i;
          state_next     = snapshot_empty ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (snapshot_empty) state_next = DONE;
      end
      DONE: begin
        if (fence_done_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_set = disp_valid_o && opc_ready_i && disp_is_mem_i;

  mem_tag_tracker #(
    .NumTags (NumTags),
    .TagWidth(TagWidth)
  ) u_tracker (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .set_valid_i     (mem_set),
    .set_tag_i       (disp_tag_i),
    .clr_valid_i     (mem_retire_valid_i),
    .clr_tag_i       (mem_retire_tag_i),
    .snap_take_i     (fence_fire),
    .snapshot_empty_o(snapshot_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      fence_tag_reg <= '0;
    end else begin
      state_reg     <= state_next;
      fence_tag_reg <= fence_tag_next;
    end
  end

  // Outputs are forced low while reset is asserted so an interrupted fence
  // never produces a completion.
  assign fence_done_valid_o = rst_ni && (state_reg == DONE);
  assign fence_done_tag_o   = fence_done_valid_o ? fence_tag_reg : '0;
  assign fence_active_o     = rst_ni && (state_reg != IDLE);

endmodule : mem_fence_ctrl

// File: tb/tb_mem_fence_ctrl.sv
module tb_mem_fence_ctrl;

  localparam int NT = 8;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       disp_valid_i = 1'b0;
  logic       disp_ready_o;
  logic [2:0] disp_tag_i = '0;
  logic       disp_is_mem_i = 1'b0;
  logic       disp_is_fence_i = 1'b0;
  logic       disp_valid_o;
  logic       opc_ready_i = 1'b0;
  logic       mem_retire_valid_i = 1'b0;
  logic [2:0] mem_retire_tag_i = '0;
  logic       fence_done_valid_o;
  logic       fence_done_ready_i = 1'b0;
  logic [2:0] fence_done_tag_o;
  logic       fence_active_o;

  always #5 clk_i = ~clk_i;

  mem_fence_ctrl dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .disp_valid_i      (disp_valid_i),
    .disp_ready_o      (disp_ready_o),
    .disp_tag_i        (disp_tag_i),
    .disp_is_mem_i     (disp_is_mem_i),
    .disp_is_fence_i   (disp_is_fence_i),
    .disp_valid_o      (disp_valid_o),
    .opc_ready_i       (opc_ready_i),
    .mem_retire_valid_i(mem_retire_valid_i),
    .mem_retire_tag_i  (mem_retire_tag_i),
    .fence_done_valid_o(fence_done_valid_o),
    .fence_done_ready_i(fence_done_ready_i),
    .fence_done_tag_o  (fence_done_tag_o),
    .fence_active_o    (fence_active_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which tags are in flight, whether a fence is pending,
  // its tag, and the set of tags that fence still waits for.
  bit out_m[NT];
  bit wait_m[NT];
  bit act_m = 1'b0;
  int ftag_m = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, obs, exp, $time);
    end
  endtask

  function automatic bit waiting_empty();
    for (int i = 0; i < NT; i++) if (wait_m[i]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock cycle: apply inputs, compare outputs against the model,
  // then advance the model across the clock edge.
  task automatic cyc(input bit rn, input bit dv, input int tg, input bit im, input bit ifn,
                     input bit ordy, input bit rv, input int rt, input bit fdr);
    bit blk, ev, er, dval, facc;
    int dtag;
    bit snap[NT];
    @(negedge clk_i);
    rst_ni             = rn;
    disp_valid_i       = dv;
    disp_tag_i         = 3'(tg);
    disp_is_mem_i      = im;
    disp_is_fence_i    = ifn;
    opc_ready_i        = ordy;
    mem_retire_valid_i = rv;
    mem_retire_tag_i   = 3'(rt);
    fence_done_ready_i = fdr;
    #1;
`ifdef BGPU_FENCE_BLOCK_ALL_EN
    blk = act_m;
`else
    blk = act_m && (im || ifn);
`endif
    ev = 1'b0;
    er = 1'b0;
    if (rn && !blk) begin
      if (ifn) er = 1'b1;
      else begin
        ev = dv;
        er = ordy;
      end
    end
    dval = rn && act_m && waiting_empty();
    dtag = dval ? ftag_m : 0;
    check("disp_valid", 32'(disp_valid_o), 32'(ev));
    check("disp_ready", 32'(disp_ready_o), 32'(er));
    check("done_valid", 32'(fence_done_valid_o), 32'(dval));
    check("done_tag", 32'(fence_done_tag_o), 32'(dtag));
    check("fence_active", 32'(fence_active_o), 32'(rn && act_m));
    facc = rn && dv && ifn && !blk;
    @(posedge clk_i);
    if (!rn) begin
      for (int i = 0; i < NT; i++) begin
        out_m[i]  = 1'b0;
        wait_m[i] = 1'b0;
      end
      act_m  = 1'b0;
      ftag_m = 0;
    end else begin
      snap = out_m;
      if (rv) snap[rt] = 1'b0;
      if (dval && fdr) begin
        act_m = 1'b0;
        $display("[TB] fence done   tag %0d", ftag_m);
      end
      if (rv) begin
        out_m[rt]  = 1'b0;
        wait_m[rt] = 1'b0;
      end
      if (facc) begin
        act_m  = 1'b1;
        ftag_m = tg;
        wait_m = snap;
        $display("[TB] fence accept tag %0d", tg);
      end
      if (ev && ordy && im) begin
        out_m[tg] = 1'b1;
        $display("[TB] mem forward  tag %0d", tg);
      end
    end
  endtask

  // Shorthands: idle cycle, memory offer, ALU offer, fence offer, retire.
  task automatic idle(input bit fdr);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, fdr);
  endtask

  initial begin
    int kind;
    // Reset state
    repeat (3) cyc(0, 1, 2, 1, 0, 1, 1, 2, 1);

    // Fence with nothing outstanding: completion one cycle later
    cyc(1, 1, 3, 0, 1, 1, 0, 0, 1);
    idle(1);
    idle(1);

    // Two memory instructions, fence, retire 2 then 1
    cyc(1, 1, 1, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 2, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 5, 0, 1, 1, 0, 0, 0);
    cyc(1, 1, 4, 1, 0, 1, 0, 0, 0);   // held in DRAIN
    cyc(1, 0, 0, 0, 0, 1, 1, 2, 0);
    cyc(1, 0, 0, 0, 0, 1, 1, 1, 1);
    idle(1);
    idle(1);

    // Same-cycle retire at fence handshake drops that tag from the snapshot
    cyc(1, 1, 1, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 2, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 6, 0, 1, 1, 1, 1, 0);
    idle(0);
    cyc(1, 0, 0, 0, 0, 1, 1, 2, 1);
    idle(1);
    idle(1);

    // ALU during DRAIN passes (or is blocked with the full barrier)
    cyc(1, 1, 3, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 1, 0, 0, 0);
    cyc(1, 1, 4, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 7, 0, 0, 1, 0, 0, 0);
    cyc(1, 1, 7, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 1, 3, 1);
    idle(1);
    idle(1);

    // DONE held while result bus stalls
    cyc(1, 1, 2, 0, 1, 1, 0, 0, 0);
    repeat (4) idle(0);
    idle(1);
    cyc(1, 1, 4, 1, 0, 1, 0, 0, 0);   // memory unblocked right after accept
    cyc(1, 0, 0, 0, 0, 1, 1, 4, 0);

    // Reset during DRAIN, then an empty fence completes in one cycle
    cyc(1, 1, 4, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 7, 0, 1, 1, 0, 0, 0);
    idle(0);
    cyc(0, 1, 1, 1, 0, 1, 0, 0, 0);
    cyc(1, 1, 2, 0, 1, 1, 0, 0, 0);
    idle(1);
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      kind = $urandom_range(0, 9);
      cyc($urandom_range(0, 199) != 0,
          $urandom_range(0, 3) != 0,
          $urandom_range(0, NT - 1),
          (kind >= 1 && kind <= 5),
          (kind == 0),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, NT - 1),
          $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_fence_ctrl
